rr_wgt_arb: RTL
===============

Name: rr_wgt_arb

Overview:
- Weighted round-robin arbiter: next-generation successor of rr_top.
- Same request/grant interface style as rr_top, with additions:
  - a grant/acknowledge handshake;
  - a per-requester weight, meaning consecutive grants allowed per turn;
  - a run-time mode select between plain RR and weighted RR.
- Sits in front of a shared resource (bus port, memory channel); each acknowledged transfer consumes one credit of the current owner.

Parameters:
- REQCNT, 16, number of requesters (>=2).
- WGT_W, 4, weight width in bits; max burst per turn = 2**WGT_W-1.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset. Synchronous, active-high.
- req_i  input  REQCNT  request vector, level-sensitive, bit i = requester i.
- req_val_i  input  1  qualifier; when 0, req_i is treated as all-zero.
- weight_i  input  REQCNT*WGT_W  packed per-requester weights, requester i at bits [i*WGT_W +: WGT_W]; sampled on credit reload only.
- mode_i  input  1  0 = plain RR (one grant per turn), 1 = weighted RR.
- ack_i  input  1  resource accepted one transfer from the current owner this cycle.
- req_num_o  output  $clog2(REQCNT)  index of the granted requester.
- req_num_val_o  output  1  req_num_o is valid.
- gnt_oh_o  output  REQCNT  one-hot grant, equal to req_num_val_o ? 1<<req_num_o : 0.
- credit_o  output  WGT_W  remaining credits of the current owner, including the transfer in flight.

Behaviour:
- Reset values:
  - req_num_o = 0, req_num_val_o = 0, gnt_oh_o = 0, credit_o = 0.
  - Priority pointer ptr = 0, so requester 0 has highest priority first.
- Effective request: ereq = req_val_i ? req_i : 0.
- Selection (combinational): first set bit of ereq searching ptr, ptr+1, … REQCNT-1, 0, … ptr-1, with wrap-around.
- All outputs are registered; grant latency is 1 cycle from request to req_num_val_o.
- FSM states: IDLE, GRANT.
- IDLE:
  - If ereq != 0: go to GRANT next cycle with req_num_o = sel.
  - Load credit = (mode_i ? weight_i[sel] : 1). A weight of 0 is treated as 1.
  - Else stay in IDLE.
- GRANT, evaluated each cycle with owner g:
  - (a) ack_i=1 and credit>1 and ereq[g]=1: hold g, credit -= 1.
  - (b) ack_i=1 and (credit==1 or ereq[g]=0): turn ends.
  - (c) ack_i=0 and ereq[g]=0 (owner withdrew): turn ends, no credit consumed.
  - (d) ack_i=0 and ereq[g]=1: hold everything unchanged. The grant never changes without ack or withdrawal.
- Turn end:
  - ptr <- g+1 (mod REQCNT).
  - Selection is recomputed in the same cycle using the new ptr and with bit g masked.
  - If another request exists: GRANT to it next cycle (zero-bubble handover), credit reloaded from weight_i.
  - Else: if ereq[g] is still 1, g is re-granted with a fresh reload; otherwise go to IDLE, req_num_val_o=0, credit_o=0.
- Mode change mid-turn: takes effect at the next reload only. Credits of the current owner are not truncated.
- ack_i while req_num_val_o=0: ignored.
- Starvation bound: a continuously requesting channel is granted within (REQCNT-1) turns. Wait time in acked transfers <= sum of the other channels' weights.
- Synchronous reset mid-turn: grant is dropped on the next edge and the pointer returns to 0. In-flight credit is discarded.
- Non-power-of-2 REQCNT: pointer wrap is performed modulo REQCNT, never via natural overflow.

Decomposition:
- Package rr_arb_pkg:
  - state enum {IDLE, GRANT};
  - function wrap_inc(idx, REQCNT);
  - localparams IDX_W = $clog2(REQCNT) and a weight-zero-to-one helper.
- Sub-module rr_prio_sel: purely combinational rotating-priority finder.
  - Inputs: req, ptr, mask index.
  - Outputs: sel index, sel_val.
  - Instantiated once. Unit-testable alone against a reference loop.

Test Plan (REQCNT=4, WGT_W=4):
1. Reset, req_i=4'b1111, mode_i=0, ack_i=1 every cycle -> req_num_o sequence 0,1,2,3,0 on consecutive cycles, with req_num_val_o=1 from cycle 1 onward and no bubbles.
2. mode_i=1, weights {1,2,3,0} for requesters 3..0 (so requester 0 has weight 0), req_i=4'b1111, ack_i=1 -> owners 0 (1 grant, weight 0 treated as 1), 1 x3, 2 x2, 3 x1, repeating; credit_o counts 3,2,1 during requester 1's turn.
3. Owner 2 granted with credit 3, ack_i held 0 for 5 cycles -> req_num_o=2 stable, credit_o=3 stable; then req_i[2] drops -> next cycle grant passes to 3 (if requesting), credit unchanged by the drop.
4. Only req_i[1]=1, weight 4, ack_i=1 for 6 cycles -> req_num_o=1 for all 6 cycles (reload after 4 acks since no other requester), req_num_val_o never drops.
5. req_val_i=0 with req_i=4'b1010 -> req_num_val_o remains 0. Then assert rst_i during a GRANT -> next edge all outputs 0, and the following arbitration starts from requester 0.
6. Randomized req_i/ack_i for 10k cycles with weights all 15 -> scoreboard confirms the max wait for any held request is <= 45 acked transfers and gnt_oh_o stays one-hot.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package rr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Default geometry; IDX_W is the index width that matches DEF_REQCNT.
  localparam int DEF_REQCNT = 16;
  localparam int DEF_WGT_W  = 4;
  localparam int IDX_W      = $clog2(DEF_REQCNT);

  // Increment an index modulo n explicitly, so a non-power-of-2 requester
  // count never relies on natural counter overflow.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

  // A weight of zero still buys one transfer per turn.
  function automatic int wgt_nz(input int w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_prio_sel.sv
// Rotating-priority finder. It returns the first set request found when
// searching from ptr upward with wrap-around. The mask index, when enabled,
// hides one requester from the search.
module rr_prio_sel
  import rr_arb_pkg::*;
#(
  parameter int REQCNT = DEF_REQCNT,
  parameter int SEL_W  = $clog2(REQCNT)
) (
  input  logic [REQCNT-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              mask_en,
  input  logic [SEL_W-1:0]  mask,
  output logic [SEL_W-1:0]  sel,
  output logic              sel_val
);

  logic [REQCNT-1:0] req_m;

  // Remove the masked requester from the candidate set.
  assign req_m = req & ~(REQCNT'(mask_en) << mask);

  // Walk the candidates in priority order and keep the first hit.
  // NOTE: combinational logic uses blocking assignments, and every output
  // gets a default before the loop so no latch is inferred.
  always_comb begin
    int k;
    sel     = '0;
    sel_val = 1'b0;
    k       = 0;
    for (int i = 0; i < REQCNT; i++) begin
      k = int'(ptr) + i;
      if (k >= REQCNT) k = k - REQCNT;
      if (!sel_val && req_m[k]) begin
        sel     = SEL_W'(k);
        sel_val = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_wgt_arb.sv
// Weighted round-robin arbiter with a grant/acknowledge handshake. Each
// acknowledged transfer consumes one credit of the current owner, and the turn
// passes on when the credits run out or the owner withdraws its request.
module rr_wgt_arb
  import rr_arb_pkg::*;
#(
  parameter int REQCNT = DEF_REQCNT,
  parameter int WGT_W  = DEF_WGT_W
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [REQCNT-1:0]         req_i,
  input  logic                      req_val_i,
  input  logic [REQCNT*WGT_W-1:0]   weight_i,
  input  logic                      mode_i,
  input  logic                      ack_i,
  output logic [$clog2(REQCNT)-1:0] req_num_o,
  output logic                      req_num_val_o,
  output logic [REQCNT-1:0]         gnt_oh_o,
  output logic [WGT_W-1:0]          credit_o
);

  localparam int SEL_W = $clog2(REQCNT);

  state_t            state_q;
  logic [SEL_W-1:0]  ptr_q;
  logic [REQCNT-1:0] ereq;
  logic [SEL_W-1:0]  sel_ptr;
  logic [SEL_W-1:0]  sel;
  logic              sel_val;
  logic              in_grant;
  logic              owner_req;
  logic              turn_end;
  logic              do_grant;
  logic              do_regrant;
  logic              do_release;
  logic              do_dec;

  // Credit loaded at the start of a turn. Mode and weights are looked at here
  // only, so a mid-turn change never truncates the running turn.
  function automatic logic [WGT_W-1:0] reload(
    input logic                    mode,
    input logic [REQCNT*WGT_W-1:0] wgt,
    input logic [SEL_W-1:0]        idx
  );
    if (!mode) return WGT_W'(1);
    return WGT_W'(wgt_nz(int'(wgt[int'(idx)*WGT_W +: WGT_W])));
  endfunction

  assign ereq      = req_val_i ? req_i : '0;
  assign in_grant  = (state_q == GRANT);
  assign owner_req = ereq[req_num_o];

  // While granted, the search already starts past the owner and hides it, so
  // the handover at turn end costs no idle cycle.
  assign sel_ptr = in_grant ? SEL_W'(wrap_inc(int'(req_num_o), REQCNT)) : ptr_q;

  rr_prio_sel #(
    .REQCNT (REQCNT),
    .SEL_W  (SEL_W)
  ) u_prio_sel (
    .req     (ereq),
    .ptr     (sel_ptr),
    .mask_en (in_grant),
    .mask    (req_num_o),
    .sel     (sel),
    .sel_val (sel_val)
  );

  // Turn ends on the last credited ack or when the owner withdraws; without an
  // ack and with the request still held, the grant is frozen.
  assign turn_end = in_grant &&
                    (ack_i ? (credit_o == WGT_W'(1) || !owner_req) : !owner_req);

  assign do_grant   = sel_val && (!in_grant || turn_end);
  assign do_regrant = turn_end && !sel_val && owner_req;
  assign do_release = turn_end && !sel_val && !owner_req;
  assign do_dec     = in_grant && !turn_end && ack_i;

  // Arbitration FSM with registered outputs; the pointer moves past the owner
  // at each turn end.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      req_num_o     <= '0;
      req_num_val_o <= 1'b0;
      gnt_oh_o      <= '0;
      credit_o      <= '0;
    end else begin
      if (turn_end) ptr_q <= sel_ptr;
      if (do_grant) begin
        state_q       <= GRANT;
        req_num_o     <= sel;
        req_num_val_o <= 1'b1;
        gnt_oh_o      <= REQCNT'(1) << sel;
        credit_o      <= reload(mode_i, weight_i, sel);
      end else if (do_regrant) begin
        credit_o <= reload(mode_i, weight_i, req_num_o);
      end else if (do_release) begin
        state_q       <= IDLE;
        req_num_val_o <= 1'b0;
        gnt_oh_o      <= '0;
        credit_o      <= '0;
      end else if (do_dec) begin
        credit_o <= credit_o - WGT_W'(1);
      end
    end
  end

endmodule
